// File: rtl/reg_file.sv
// Purpose : 2**ADDR_W x DATA_W integer register file, x0 hardwired to zero,
//           one write port and two combinational read ports with write-first bypass.
// Latency : reads are zero-cycle (combinational); writes land on the rising clk edge.
// Backpressure: none; every write with we=1 is accepted in the cycle it is presented.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst            synchronous active-high reset, clears every register, beats we
//   we/waddr/wdata write port (writes to index 0 are dropped)
//   raddr1/rdata1  read port 1 (rs1)
//   raddr2/rdata2  read port 2 (rs2)
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  wsel;
    logic              wr_live;

    // One-hot write decode. Bit 0 is forced low so x0 can never be written;
    // x0 is only ever touched by reset.
    always_comb begin
        wsel        = '0;
        wsel[waddr] = 1'b1;
        wsel[0]     = 1'b0;
    end

    // A write that will actually commit at the next edge. Reset suppresses it,
    // which also suppresses the bypass so reads during reset show storage.
    assign wr_live = we && !rst && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Read port 1: x0 masks to zero regardless of storage (which is undefined
    // before the first reset), then the in-flight write wins over storage.
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wr_live && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
    end

    // Read port 2: identical selection, evaluated independently.
    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wr_live && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Purpose : self-checking bench for reg_file (table vectors, directed sweeps, random vs model).
// Latency : inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: not applicable.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    int checks   = 0;
    int failures = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    // Reference storage: the architectural register contents as the spec defines them.
    logic [31:0] model [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one cycle of inputs at the falling edge; outputs settle 1 unit later.
    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        rst    = r;
        we     = w;
        waddr  = wa;
        wdata  = wd;
        raddr1 = a1;
        raddr2 = a2;
        #1;
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!rst && we && (waddr == a)) return wdata;
        return model[a];
    endfunction

    // Apply what the coming edge does to the architectural state.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
    endtask

    initial begin
        //          rst  we   waddr  wdata          ra1    ra2    exp1           exp2
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'h0000_0001, 5'd5,  5'd0,  32'h0000_0001, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd5,  32'h0000_0000, 5'd5,  5'd5,  32'h0000_0001, 32'h0000_0001};
        vecs[2]  = '{1'b0, 1'b1, 5'd5,  32'hFFFF_FFFE, 5'd5,  5'd5,  32'hFFFF_FFFE, 32'hFFFF_FFFE};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'hFFFF_FFFE, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'hFFFF_FFFE};
        vecs[6]  = '{1'b0, 1'b1, 5'd7,  32'h0000_0002, 5'd7,  5'd5,  32'h0000_0002, 32'hFFFF_FFFE};
        vecs[7]  = '{1'b0, 1'b1, 5'd7,  32'h0000_0003, 5'd7,  5'd7,  32'h0000_0003, 32'h0000_0003};
        vecs[8]  = '{1'b0, 1'b0, 5'd7,  32'h0,         5'd7,  5'd7,  32'h0000_0003, 32'h0000_0003};
        vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h0000_000A, 5'd3,  5'd7,  32'h0000_000A, 32'h0000_0003};
        vecs[10] = '{1'b0, 1'b0, 5'd3,  32'h0000_0055, 5'd3,  5'd3,  32'h0000_000A, 32'h0000_000A};
        vecs[11] = '{1'b1, 1'b1, 5'd3,  32'h0000_000B, 5'd3,  5'd7,  32'h0000_000A, 32'h0000_0003};
        vecs[12] = '{1'b0, 1'b0, 5'd3,  32'h0,         5'd3,  5'd7,  32'h0,         32'h0};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd3,  5'd5,  32'h0,         32'h0};
        vecs[14] = '{1'b0, 1'b1, 5'd9,  32'h1234_5678, 5'd10, 5'd9,  32'h0,         32'h1234_5678};
        vecs[15] = '{1'b0, 1'b1, 5'd10, 32'hCAFE_F00D, 5'd9,  5'd10, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[16] = '{1'b1, 1'b0, 5'd0,  32'h0,         5'd9,  5'd10, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[17] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd9,  5'd10, 32'h0,         32'h0};

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

        // Two reset cycles, then every index on both ports must read zero.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, i[4:0], 5'(31 - i));
            check($sformatf("reset_r1[%0d]", i), rdata1, 32'h0);
            check($sformatf("reset_r2[%0d]", 31 - i), rdata2, 32'h0);
        end

        // Table vectors: outputs checked before the edge that commits each row.
        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].ra1, vecs[v].ra2);
            check($sformatf("vec%0d_r1", v), rdata1, vecs[v].e1);
            check($sformatf("vec%0d_r2", v), rdata2, vecs[v].e2);
        end

        // Fill x1..x31 with their own index, then sweep both ports in opposite directions.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, i[4:0], 32'(i), i[4:0], 5'd0);
            check($sformatf("fill_bypass[%0d]", i), rdata1, 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, i[4:0], 5'(31 - i));
            check($sformatf("sweep_r1[%0d]", i), rdata1, 32'(i));
            check($sformatf("sweep_r2[%0d]", 31 - i), rdata2, 32'(31 - i));
        end

        // Mid-sequence reset clears everything in one edge.
        drive(1'b1, 1'b1, 5'd20, 32'h0BAD_0BAD, 5'd20, 5'd31);
        check("midrst_pre_r1", rdata1, 32'd20);
        check("midrst_pre_r2", rdata2, 32'd31);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd31);
        check("midrst_post_r1", rdata1, 32'h0);
        check("midrst_post_r2", rdata2, 32'h0);

        // Random traffic against the architectural model (storage known-zero now).
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic        r, w;
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            r  = ($urandom_range(0, 24) == 0);
            w  = ($urandom_range(0, 2) != 0);
            wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(r, w, wa, wd, a1, a2);
            check($sformatf("rand%0d_r1", n), rdata1, ref_read(a1));
            check($sformatf("rand%0d_r2", n), rdata2, ref_read(a2));
            model_edge();
        end

        // Final storage dump through both ports.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, i[4:0], i[4:0]);
            check($sformatf("dump_r1[%0d]", i), rdata1, (i == 0) ? 32'h0 : model[i]);
            check($sformatf("dump_r2[%0d]", i), rdata2, (i == 0) ? 32'h0 : model[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W (32 for RV32I).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 we  input  1  write enable for the write port.
REQ-006 waddr  input  ADDR_W  destination register index (rd).
REQ-007 wdata  input  DATA_W  write-back data.
REQ-008 raddr1  input  ADDR_W  read port 1 index (rs1).
REQ-009 raddr2  input  ADDR_W  read port 2 index (rs2).
REQ-010 rdata1  output  DATA_W  read port 1 data.
REQ-011 rdata2  output  DATA_W  read port 2 data.

Function
REQ-012 Storage SHALL be 2**ADDR_W registers of DATA_W bits; index 0 is x0.
REQ-013 Write port SHALL decode waddr, one-hot, to exactly one register; on rising clk with we=1, rst=0, waddr!=0 that register SHALL take wdata; all other registers SHALL hold.
REQ-014 Writes with waddr=0 SHALL be discarded; x0 SHALL read 32'h0000_0000 at all times.
REQ-015 we=0 SHALL leave all registers unchanged regardless of waddr/wdata.
REQ-016 Read ports SHALL be combinational, zero-cycle latency, from raddrN to rdataN.
REQ-017 Write-first bypass: when we=1, rst=0, waddr!=0 and raddrN==waddr, rdataN SHALL equal wdata in the same cycle, before the edge.
REQ-018 Bypass SHALL apply independently to each port; both ports on the same address SHALL return identical data.
REQ-019 raddrN=0 SHALL return 0 even when we=1 and waddr=0, i.e. there is no bypass of x0.
REQ-020 After an edge, a written value SHALL be returned from storage with no bypass dependency.
REQ-021 Simultaneous write to register k and read of register j!=k SHALL return the stored value of j, unaffected.
REQ-022 No width conversion; wdata is stored bit-exact with no sign or zero extension inside the block.

Reset
REQ-023 On a rising clk with rst=1, all registers SHALL become 0; rst SHALL take priority over we.
REQ-024 While rst=1, bypass SHALL be suppressed; rdataN SHALL reflect storage contents, which are 0 after the first reset edge.
REQ-025 A write that coincides with rst=1 SHALL be lost and SHALL NOT appear after reset deasserts.
REQ-026 rst asserted mid-sequence SHALL clear all prior writes within one edge; there is no partial clear.
REQ-027 Before the first reset edge, contents are undefined; verification SHALL apply rst for at least 1 cycle first.

Verification
REQ-028 rst=1 for 2 cycles, then read all 32 indices on both ports -> every rdata = 0.
REQ-029 we=1, waddr=5, wdata=32'h0000_0001, edge; then raddr1=5 -> rdata1=1; then write 32'hFFFF_FFFE to 5 -> rdata1=32'hFFFF_FFFE (-2 signed).
REQ-030 we=1, waddr=0, wdata=32'hDEAD_BEEF, raddr1=0 -> rdata1=0 before and after the edge.
REQ-031 Register 7 holds 32'h2; in the same cycle set we=1, waddr=7, wdata=32'h3, raddr1=7, raddr2=7 -> rdata1=rdata2=3 pre-edge; post-edge with we=0 -> both 3.
REQ-032 Register 3 holds 32'hA; rst=1 together with we=1, waddr=3, wdata=32'hB -> rdata for 3 is 0 after the edge, and stays 0 after rst drops.
REQ-033 Write 1..31 to x1..x31 (value=index), then sweep raddr1 upward and raddr2 downward -> each port returns its index; x0 returns 0.
